// File: rtl/vector_lane_sequencer_if.sv
// Bundle between the vector decode stage, the sequencer and the shared lane.
//   slave  : the sequencer (takes the request and lane_res, drives the lane).
//   master : decode stage plus lane (drives the request and lane_res).
// Handshake: start is a level request, accepted only in IDLE or DONE. Operands are
// captured on the accepting edge. done is a one-cycle pulse, and result holds until
// the next accepted start. The sequencer gives no ready indication, so a start that
// arrives while busy=1 is dropped.
interface vector_lane_sequencer_if #(
   parameter int LANES = 4,
   parameter int LW    = 16
);
   localparam int VW = LANES * LW;
   localparam int IW = $clog2(LANES);

   logic          start;
   logic [1:0]    op;
   logic          size;
   logic [VW-1:0] vec;
   logic [IW-1:0] idx;
   logic [LW-1:0] srcb;
   logic          busy;
   logic          done;
   logic [VW-1:0] result;
   logic [2:0]    lane_ctrl;
   logic [IW-1:0] lane_id;
   logic [LW-1:0] lane_v;
   logic [IW-1:0] lane_idx;
   logic [LW-1:0] lane_srcb;
   logic [LW-1:0] lane_res;
   logic [1:0]    dbg_state;

   modport slave (
      input  start, op, size, vec, idx, srcb, lane_res,
      output busy, done, result, lane_ctrl, lane_id, lane_v, lane_idx, lane_srcb,
             dbg_state
   );

   modport master (
      output start, op, size, vec, idx, srcb, lane_res,
      input  busy, done, result, lane_ctrl, lane_id, lane_v, lane_idx, lane_srcb,
             dbg_state
   );
endinterface

// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: time-multiplexes one shared LW-bit lane over the LANES slots
// of a vector operand. It issues one slot per cycle and assembles the result vector.
// Optional feature macro: LANE_SEQ_PIPE_EN. When this macro is defined, lane_res is
// registered before it is written back. That adds a DRAIN state and one cycle of latency.
// All lane_* outputs are registered. They are loaded for slot 0 on the accepting edge
// and advanced on each ISSUE edge, so the lane sees a stable operand for the whole cycle.
module vector_lane_sequencer #(
   parameter int LANES = 4,
   parameter int LW    = 16
) (
   input logic                    clk,
   input logic                    rst,
   vector_lane_sequencer_if.slave bus
);
   localparam int VW = LANES * LW;
   localparam int IW = $clog2(LANES);
   localparam logic [IW-1:0] LAST = IW'(LANES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t        state;
   logic [IW-1:0] cnt;
   logic [IW-1:0] nxt;
   logic [VW-1:0] vec_q;
`ifdef LANE_SEQ_PIPE_EN
   logic [LW-1:0] res_q;
   logic [IW-1:0] prv;
`endif

   assign nxt           = cnt + 1'b1;
`ifdef LANE_SEQ_PIPE_EN
   assign prv           = cnt - 1'b1;
`endif
   assign bus.dbg_state = state;

   // Sequencer FSM: accept, per-slot issue and write-back, completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         vec_q         <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.result    <= '0;
         bus.lane_ctrl <= '0;
         bus.lane_id   <= '0;
         bus.lane_v    <= '0;
         bus.lane_idx  <= '0;
         bus.lane_srcb <= '0;
`ifdef LANE_SEQ_PIPE_EN
         res_q         <= '0;
`endif
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  state         <= S_ISSUE;
                  bus.busy      <= 1'b1;
                  cnt           <= '0;
                  vec_q         <= bus.vec;
                  bus.result    <= '0;
                  bus.lane_ctrl <= {bus.op, bus.size};
                  bus.lane_id   <= '0;
                  bus.lane_v    <= bus.vec[LW-1:0];
                  bus.lane_idx  <= bus.idx;
                  bus.lane_srcb <= bus.srcb;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_ISSUE: begin
`ifdef LANE_SEQ_PIPE_EN
               // The slot issued last cycle is written back from the holding register.
               res_q <= bus.lane_res;
               if (cnt != '0)
                  bus.result[prv*LW +: LW] <= res_q;
`else
               bus.result[cnt*LW +: LW] <= bus.lane_res;
`endif
               cnt <= nxt;
               if (cnt == LAST) begin
                  bus.lane_ctrl <= '0;
                  bus.lane_id   <= '0;
                  bus.lane_v    <= '0;
                  bus.lane_idx  <= '0;
                  bus.lane_srcb <= '0;
`ifdef LANE_SEQ_PIPE_EN
                  state         <= S_DRAIN;
`else
                  state         <= S_DONE;
                  bus.busy      <= 1'b0;
                  bus.done      <= 1'b1;
`endif
               end else begin
                  bus.lane_id <= nxt;
                  bus.lane_v  <= vec_q[nxt*LW +: LW];
               end
            end
            S_DRAIN: begin
`ifdef LANE_SEQ_PIPE_EN
               bus.result[LAST*LW +: LW] <= res_q;
`endif
               state    <= S_DONE;
               bus.busy <= 1'b0;
               bus.done <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed bench for vector_lane_sequencer. It includes a behavioural model of the
// shared lane. Define LANE_SEQ_PIPE_EN for the bench and the RTL together.
module tb_vector_lane_sequencer;
`ifdef LANE_SEQ_PIPE_EN
   localparam int DONE_CYC = 6;
`else
   localparam int DONE_CYC = 5;
`endif

   logic clk;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   vector_lane_sequencer_if bus ();

   vector_lane_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Lane model: DIVS/MODS are signed, MULS keeps the low LW bits, INC bumps the idx slot only.
   logic [15:0] lane_out;
   always_comb begin
      lane_out = bus.lane_v;
      case (bus.lane_ctrl[2:1])
         2'b00: lane_out = (bus.lane_srcb == 16'd0) ? 16'd0 :
                           16'($signed(bus.lane_v) / $signed(bus.lane_srcb));
         2'b01: lane_out = 16'(bus.lane_v * bus.lane_srcb);
         2'b10: lane_out = (bus.lane_id == bus.lane_idx) ? 16'(bus.lane_v + 16'd1) : bus.lane_v;
         2'b11: lane_out = (bus.lane_srcb == 16'd0) ? 16'd0 :
                           16'($signed(bus.lane_v) % $signed(bus.lane_srcb));
         default: lane_out = bus.lane_v;
      endcase
   end
   assign bus.lane_res = lane_out;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input logic [1:0] o, input logic s, input logic [63:0] v,
                          input logic [1:0] ix, input logic [15:0] b);
      bus.start = 1'b1;
      bus.op    = o;
      bus.size  = s;
      bus.vec   = v;
      bus.idx   = ix;
      bus.srcb  = b;
   endtask

   // Drop start and scramble the operands so a late capture is visible.
   task automatic drop_req();
      bus.start = 1'b0;
      bus.op    = ~bus.op;
      bus.size  = ~bus.size;
      bus.vec   = ~bus.vec;
      bus.idx   = ~bus.idx;
      bus.srcb  = bus.srcb + 16'd1;
   endtask

   // One full operation: checks every issue cycle, the latency, the result, and the result hold.
   task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                         input logic [63:0] v, input logic [1:0] ix, input logic [15:0] b,
                         input logic [63:0] exp_res);
      int cyc;
      @(negedge clk);
      set_req(o, s, v, ix, b);
      @(negedge clk);
      drop_req();
      cyc = 1;
      chk({tag, " result cleared"}, bus.result, 64'd0);
      while (bus.done !== 1'b1 && cyc < 20) begin
         if (cyc <= 4) begin
            chk({tag, " busy"},      {63'd0, bus.busy}, 64'd1);
            chk({tag, " lane_id"},   {62'd0, bus.lane_id}, 64'(cyc - 1));
            chk({tag, " lane_v"},    {48'd0, bus.lane_v}, {48'd0, v[(cyc-1)*16 +: 16]});
            chk({tag, " lane_ctrl"}, {61'd0, bus.lane_ctrl}, {61'd0, o, s});
            chk({tag, " lane_idx"},  {62'd0, bus.lane_idx}, {62'd0, ix});
            chk({tag, " lane_srcb"}, {48'd0, bus.lane_srcb}, {48'd0, b});
         end
         @(negedge clk);
         cyc++;
      end
      chk({tag, " latency"}, 64'(cyc), 64'(DONE_CYC));
      chk({tag, " result"}, bus.result, exp_res);
      chk({tag, " busy in done"}, {63'd0, bus.busy}, 64'd0);
      chk({tag, " lane_v in done"}, {48'd0, bus.lane_v}, 64'd0);
      @(negedge clk);
      chk({tag, " done pulse"}, {63'd0, bus.done}, 64'd0);
      chk({tag, " result hold"}, bus.result, exp_res);
   endtask

   // stimulus
   initial begin
      int cyc;
      int ndone;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.size  = 1'b0;
      bus.vec   = 64'd0;
      bus.idx   = 2'd0;
      bus.srcb  = 16'd0;
      repeat (2) @(negedge clk);
      chk("reset busy",      {63'd0, bus.busy}, 64'd0);
      chk("reset done",      {63'd0, bus.done}, 64'd0);
      chk("reset result",    bus.result, 64'd0);
      chk("reset lane_id",   {62'd0, bus.lane_id}, 64'd0);
      chk("reset lane_v",    {48'd0, bus.lane_v}, 64'd0);
      chk("reset lane_ctrl", {61'd0, bus.lane_ctrl}, 64'd0);
      rst = 1'b0;

      run_op("divs", 2'b00, 1'b0, 64'h0009_000C_0015_001E, 2'd0, 16'd3, 64'h0003_0004_0007_000A);
      run_op("muls", 2'b01, 1'b1, 64'h0007_0007_0007_0007, 2'd2, 16'd7, 64'h0031_0031_0031_0031);
      run_op("inc",  2'b10, 1'b0, 64'h0004_0003_0002_0001, 2'd1, 16'd0, 64'h0004_0003_0003_0001);

      // MODS, a start pulsed mid-ISSUE, then DIVS started straight out of DONE.
      ndone = 0;
      @(negedge clk);
      set_req(2'b11, 1'b0, 64'h0007_0007_0007_0007, 2'd0, 16'd7);
      @(negedge clk);
      drop_req();
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 20) begin
         if (cyc == 2) set_req(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 16'd5);
         else bus.start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      if (bus.done === 1'b1) ndone++;
      chk("mods latency", 64'(cyc), 64'(DONE_CYC));
      chk("mods result", bus.result, 64'd0);
      set_req(2'b00, 1'b0, 64'h0009_000C_0015_001E, 2'd0, 16'd3);
      @(negedge clk);
      drop_req();
      chk("b2b busy", {63'd0, bus.busy}, 64'd1);
      chk("b2b done low", {63'd0, bus.done}, 64'd0);
      chk("b2b lane_v slot0", {48'd0, bus.lane_v}, 64'h001E);
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("b2b latency", 64'(cyc), 64'(DONE_CYC));
      chk("b2b result", bus.result, 64'h0003_0004_0007_000A);
      repeat (4) begin
         if (bus.done === 1'b1) ndone++;
         @(negedge clk);
      end
      chk("done count", 64'(ndone), 64'd2);

      // Asynchronous reset in ISSUE cycle 2.
      @(negedge clk);
      set_req(2'b01, 1'b0, 64'h0002_0003_0004_0005, 2'd0, 16'd2);
      @(negedge clk);
      drop_req();
      repeat (2) @(negedge clk);
      chk("pre-reset lane_id", {62'd0, bus.lane_id}, 64'd2);
      #2 rst = 1'b1;
      #1;
      chk("async rst busy",      {63'd0, bus.busy}, 64'd0);
      chk("async rst done",      {63'd0, bus.done}, 64'd0);
      chk("async rst result",    bus.result, 64'd0);
      chk("async rst lane_id",   {62'd0, bus.lane_id}, 64'd0);
      chk("async rst lane_v",    {48'd0, bus.lane_v}, 64'd0);
      chk("async rst lane_ctrl", {61'd0, bus.lane_ctrl}, 64'd0);
      chk("async rst lane_srcb", {48'd0, bus.lane_srcb}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post-rst divs", 2'b00, 1'b0, 64'h0009_000C_0015_001E, 2'd0, 16'd3,
             64'h0003_0004_0007_000A);

      // report
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
